// File: rtl/core_pkg.sv
// Shared core parameters and helpers for the register file / scoreboard.
// Contents: default widths (XLEN, NREG, AW, CNT_W, port counts),
//   cnt_max()  - saturation value of a CNT_W-bit counter,
//   fld_lo()   - low bit index of field idx in a flat bus of w-bit fields.
package core_pkg;

  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_NREG    = 32;
  localparam int unsigned DEF_AW      = 5;
  localparam int unsigned DEF_CNT_W   = 2;
  localparam int unsigned DEF_NUM_WR  = 4;
  localparam int unsigned DEF_NUM_ISS = 2;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned fld_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/sb_cnt.sv
// Per-register pending-writer counter with clear and overflow look-ahead.
// Optional feature macro: REGS_BYPASS_EN (busy also reflects same-cycle writebacks).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         flush: counter cleared next edge
//   inc_ok      dispatches of this cycle are accepted
//   inc_n       number of dispatch ports targeting this register
//   dec_n       number of writeback ports targeting this register
//   busy        counter non-zero (write-first view when bypass enabled)
//   would_ovf   counter + inc_n would exceed the saturation value
module sb_cnt
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned INC_W = 2,
  parameter int unsigned DEC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_ok,
  input  logic [INC_W-1:0] inc_n,
  input  logic [DEC_W-1:0] dec_n,
  output logic             busy,
  output logic             would_ovf
);

  localparam int unsigned SW      = CNT_W + INC_W + DEC_W;
  localparam int unsigned CNT_MAX = cnt_max(CNT_W);

  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    w_up;
  logic [SW-1:0]    w_dn;
  logic [SW-1:0]    w_nxt;

  // Net update; a writeback with no pending writer floors at zero.
  always_comb begin
    w_up      = SW'(r_cnt) + (inc_ok ? SW'(inc_n) : SW'(0));
    w_dn      = SW'(dec_n);
    w_nxt     = (w_up > w_dn) ? (w_up - w_dn) : SW'(0);
    would_ovf = (SW'(r_cnt) + SW'(inc_n)) > SW'(CNT_MAX);
`ifdef REGS_BYPASS_EN
    busy      = SW'(r_cnt) > w_dn;
`else
    busy      = (r_cnt != CNT_W'(0));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || clr) r_cnt <= '0;
    else            r_cnt <= CNT_W'(w_nxt);
  end

endmodule

// File: rtl/regs_sb.sv
// Multi-port register file with a pending-writer scoreboard for id hazard checks.
// Optional feature macro: REGS_BYPASS_EN (write-first read image and busy).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   iss_en_i/rd_i   dispatch reservations (NUM_ISS ports)
//   iss_ready_o     combinational: all requested reservations fit this cycle
//   wb_we_i/waddr_i/wdata_i  writeback ports (NUM_WR), highest index wins
//   flush_i         clear all reservations, drop same-cycle dispatches
//   reg_rdata_o     flat register image, reg k at [k*XLEN +: XLEN]
//   busy_o          per-register pending-writer flag
//   wb_conflict_o   registered pulse after a same-cycle multi-port write
module regs_sb
  import core_pkg::*;
#(
  parameter int unsigned NUM_WR  = DEF_NUM_WR,
  parameter int unsigned NUM_ISS = DEF_NUM_ISS,
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned NREG    = DEF_NREG,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ISS-1:0]     iss_en_i,
  input  logic [NUM_ISS*AW-1:0]  iss_rd_i,
  output logic                   iss_ready_o,
  input  logic [NUM_WR-1:0]      wb_we_i,
  input  logic [NUM_WR*AW-1:0]   wb_waddr_i,
  input  logic [NUM_WR*XLEN-1:0] wb_wdata_i,
  input  logic                   flush_i,
  output logic [NREG*XLEN-1:0]   reg_rdata_o,
  output logic [NREG-1:0]        busy_o,
  output logic                   wb_conflict_o
);

  localparam int unsigned IW = $clog2(NUM_ISS + 1);
  localparam int unsigned DW = $clog2(NUM_WR + 1);

  logic [XLEN-1:0] r_regs [NREG];
  logic            r_conflict;

  logic [NREG-1:0] w_wr_en;
  logic [XLEN-1:0] w_wr_data [NREG];
  logic [IW-1:0]   w_inc_n [NREG];
  logic [DW-1:0]   w_dec_n [NREG];
  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_ovf;
  logic            w_conflict;
  logic            w_accept;

  // Per-register dispatch/writeback counts and the port-priority write mux.
  always_comb begin
    w_wr_en    = '0;
    w_conflict = 1'b0;
    for (int k = 0; k < int'(NREG); k++) begin
      w_wr_data[k] = '0;
      w_inc_n[k]   = '0;
      w_dec_n[k]   = '0;
    end
    for (int p = 0; p < int'(NUM_ISS); p++) begin
      if (iss_en_i[p])
        w_inc_n[iss_rd_i[fld_lo(p, AW) +: AW]] =
          w_inc_n[iss_rd_i[fld_lo(p, AW) +: AW]] + IW'(1);
    end
    // Ascending port order: the last (highest) port hitting a register wins.
    for (int p = 0; p < int'(NUM_WR); p++) begin
      if (wb_we_i[p] && (wb_waddr_i[fld_lo(p, AW) +: AW] != AW'(0))) begin
        w_wr_en[wb_waddr_i[fld_lo(p, AW) +: AW]]   = 1'b1;
        w_wr_data[wb_waddr_i[fld_lo(p, AW) +: AW]] = wb_wdata_i[fld_lo(p, XLEN) +: XLEN];
        w_dec_n[wb_waddr_i[fld_lo(p, AW) +: AW]]   =
          w_dec_n[wb_waddr_i[fld_lo(p, AW) +: AW]] + DW'(1);
      end
    end
    for (int k = 1; k < int'(NREG); k++) begin
      if (w_dec_n[k] > DW'(1)) w_conflict = 1'b1;
    end
  end

  // All-or-nothing acceptance; flush drops the cycle's dispatches.
  assign iss_ready_o = ~(|w_ovf);
  assign w_accept    = iss_ready_o && !flush_i;

  // x0 never reserved.
  assign w_busy[0] = 1'b0;
  assign w_ovf[0]  = 1'b0;

  for (genvar r = 1; r < int'(NREG); r++) begin : g_cnt
    sb_cnt #(
      .CNT_W (CNT_W),
      .INC_W (IW),
      .DEC_W (DW)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush_i),
      .inc_ok    (w_accept),
      .inc_n     (w_inc_n[r]),
      .dec_n     (w_dec_n[r]),
      .busy      (w_busy[r]),
      .would_ovf (w_ovf[r])
    );
  end

  // Data array; writebacks land even during flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NREG); k++) r_regs[k] <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_regs[0] <= '0;
      for (int k = 1; k < int'(NREG); k++) begin
        if (w_wr_en[k]) r_regs[k] <= w_wr_data[k];
      end
      r_conflict <= w_conflict;
    end
  end

  // Flat read image.
  always_comb begin
    reg_rdata_o = '0;
    for (int k = 0; k < int'(NREG); k++) begin
      reg_rdata_o[fld_lo(k, XLEN) +: XLEN] = r_regs[k];
`ifdef REGS_BYPASS_EN
      if (w_wr_en[k]) reg_rdata_o[fld_lo(k, XLEN) +: XLEN] = w_wr_data[k];
`endif
    end
  end

  assign busy_o        = w_busy;
  assign wb_conflict_o = r_conflict;

endmodule

// File: tb/tb_regs_sb.sv
// Directed table-driven bench for regs_sb (default parameters).
module tb_regs_sb;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   iss_en_i;
  logic [9:0]   iss_rd_i;
  logic         iss_ready_o;
  logic [3:0]   wb_we_i;
  logic [19:0]  wb_waddr_i;
  logic [127:0] wb_wdata_i;
  logic         flush_i;
  logic [1023:0] reg_rdata_o;
  logic [31:0]  busy_o;
  logic         wb_conflict_o;

  int n_pass = 0;
  int n_tot  = 0;

  regs_sb dut (
    .clk           (clk),
    .rst           (rst),
    .iss_en_i      (iss_en_i),
    .iss_rd_i      (iss_rd_i),
    .iss_ready_o   (iss_ready_o),
    .wb_we_i       (wb_we_i),
    .wb_waddr_i    (wb_waddr_i),
    .wb_wdata_i    (wb_wdata_i),
    .flush_i       (flush_i),
    .reg_rdata_o   (reg_rdata_o),
    .busy_o        (busy_o),
    .wb_conflict_o (wb_conflict_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         flush;
    logic [1:0]   iss_en;
    logic [9:0]   iss_rd;
    logic [3:0]   we;
    logic [19:0]  waddr;
    logic [127:0] wdata;
    logic         exp_ready;
    logic [31:0]  exp_busy;
    int           chk_reg;
    logic [31:0]  exp_val;
    logic         exp_conf;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic f, input logic [1:0] en,
                     input logic [4:0] rd1, input logic [4:0] rd0, input logic [3:0] we,
                     input logic [4:0] a3, input logic [4:0] a2, input logic [4:0] a1,
                     input logic [4:0] a0, input logic [31:0] d3, input logic [31:0] d2,
                     input logic [31:0] d1, input logic [31:0] d0, input logic er,
                     input logic [31:0] eb, input int creg, input logic [31:0] cval,
                     input logic ec);
    vec_t v;
    v.rst = r; v.flush = f; v.iss_en = en; v.iss_rd = {rd1, rd0};
    v.we = we; v.waddr = {a3, a2, a1, a0}; v.wdata = {d3, d2, d1, d0};
    v.exp_ready = er; v.exp_busy = eb; v.chk_reg = creg; v.exp_val = cval;
    v.exp_conf = ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step%0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic idle();
    rst = 1'b0; flush_i = 1'b0; iss_en_i = '0; iss_rd_i = '0;
    wb_we_i = '0; wb_waddr_i = '0; wb_wdata_i = '0;
  endtask

  function automatic logic [31:0] rd_reg(input int k);
    return reg_rdata_o[k*32 +: 32];
  endfunction

  initial begin
    // Reset and basic reserve/writeback.
    add(1,0,2'b00, 0,0, 4'b0000, 0,0,0,0, 0,0,0,0, 1, 32'h0, 0, 0, 0);
    add(0,0,2'b01, 0,5, 4'b0000, 0,0,0,0, 0,0,0,0, 1, 32'h20, 5, 0, 0);
    add(0,0,2'b00, 0,0, 4'b0100, 0,5,0,0, 0,32'hDEADBEEF,0,0, 1, 32'h0, 5, 32'hDEADBEEF, 0);
    // Same-cycle multi-port write: highest port wins, one-cycle pulse.
    add(0,0,2'b00, 0,0, 4'b1001, 7,0,0,7, 32'h33,0,0,32'h11, 1, 32'h0, 7, 32'h33, 1);
    add(0,0,2'b00, 0,0, 4'b0000, 0,0,0,0, 0,0,0,0, 1, 32'h0, 7, 32'h33, 0);
    // Two dispatches to x9 then a rejected pair (2+2 > 3).
    add(0,0,2'b11, 9,9, 4'b0000, 0,0,0,0, 0,0,0,0, 1, 32'h200, 9, 0, 0);
    add(0,0,2'b11, 9,9, 4'b0000, 0,0,0,0, 0,0,0,0, 0, 32'h200, 9, 0, 0);
    add(0,0,2'b00, 0,0, 4'b0001, 0,0,0,9, 0,0,0,32'h1, 1, 32'h200, 9, 32'h1, 0);
    add(0,0,2'b00, 0,0, 4'b0010, 0,0,9,0, 0,0,32'h2,0, 1, 32'h0, 9, 32'h2, 0);
    // Flush: clears cnt[3], drops x4 dispatch, keeps wb data.
    add(0,0,2'b11, 3,3, 4'b0000, 0,0,0,0, 0,0,0,0, 1, 32'h8, 3, 0, 0);
    add(0,1,2'b01, 0,4, 4'b0001, 0,0,0,3, 0,0,0,32'h55, 1, 32'h0, 3, 32'h55, 0);
    add(0,0,2'b00, 0,0, 4'b0010, 0,0,4,0, 0,0,32'h66,0, 1, 32'h0, 4, 32'h66, 0);
    // x0 stays zero and never busy.
    add(0,0,2'b01, 0,0, 4'b0001, 0,0,0,0, 0,0,0,32'hFFFFFFFF, 1, 32'h0, 0, 0, 0);
    // Dispatch and wb to the same reg net out.
    add(0,0,2'b01, 0,6, 4'b0010, 0,0,6,0, 0,0,32'hA5,0, 1, 32'h0, 6, 32'hA5, 0);
    // Saturation at 3, then a triple writeback drains it.
    add(0,0,2'b11, 10,10, 4'b0000, 0,0,0,0, 0,0,0,0, 1, 32'h400, 10, 0, 0);
    add(0,0,2'b01, 0,10, 4'b0000, 0,0,0,0, 0,0,0,0, 1, 32'h400, 10, 0, 0);
    add(0,0,2'b10, 10,0, 4'b0000, 0,0,0,0, 0,0,0,0, 0, 32'h400, 10, 0, 0);
    add(0,0,2'b00, 0,0, 4'b0111, 0,10,10,10, 0,32'hC,32'hB,32'hA, 1, 32'h0, 10, 32'hC, 1);
    // Mid-operation reset beats dispatch and writeback.
    add(0,0,2'b01, 0,12, 4'b0000, 0,0,0,0, 0,0,0,0, 1, 32'h1000, 10, 32'hC, 0);
    add(1,0,2'b01, 0,13, 4'b0001, 0,0,0,14, 0,0,0,32'h77, 1, 32'h0, 14, 0, 0);

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; flush_i = vq[i].flush;
      iss_en_i = vq[i].iss_en; iss_rd_i = vq[i].iss_rd;
      wb_we_i = vq[i].we; wb_waddr_i = vq[i].waddr; wb_wdata_i = vq[i].wdata;
      #1 chk("iss_ready", i, 32'(iss_ready_o), 32'(vq[i].exp_ready));
      @(posedge clk);
      #1 idle();
      #1;
      chk("busy", i, busy_o, vq[i].exp_busy);
      chk("reg", i, rd_reg(vq[i].chk_reg), vq[i].exp_val);
      chk("conflict", i, 32'(wb_conflict_o), 32'(vq[i].exp_conf));
    end

    // Read latency: write-first view before the edge only with bypass.
    @(negedge clk);
    iss_en_i = 2'b01; iss_rd_i = {5'd0, 5'd21};
    @(negedge clk);
    idle();
    wb_we_i = 4'b0001; wb_waddr_i = {15'd0, 5'd21}; wb_wdata_i = {96'd0, 32'h1234};
    #1;
`ifdef REGS_BYPASS_EN
    chk("pre_edge_reg", 100, rd_reg(21), 32'h1234);
    chk("pre_edge_busy", 100, 32'(busy_o[21]), 32'd0);
`else
    chk("pre_edge_reg", 100, rd_reg(21), 32'h0);
    chk("pre_edge_busy", 100, 32'(busy_o[21]), 32'd1);
`endif
    @(posedge clk);
    #1 idle();
    #1;
    chk("post_edge_reg", 101, rd_reg(21), 32'h1234);
    chk("post_edge_busy", 101, 32'(busy_o[21]), 32'd0);
    chk("reg0", 101, rd_reg(0), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
